// File: rtl/fetch_pc_sequencer.sv
// Fetch-stage sequencer: owns the PC, issues one instruction-memory request at
// a time and hands each fetched word to decode through a valid/stall handshake.
module fetch_pc_sequencer #(
  parameter int              WORD     = 64,
  parameter logic [WORD-1:0] RESET_PC = '0,
  parameter logic [WORD-1:0] PC_INC   = WORD'(4)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            branch_taken_in,
  input  logic [WORD-1:0] branch_target_in,
  input  logic            stall_in,
  output logic            imem_req_valid_out,
  output logic [WORD-1:0] imem_addr_out,
  input  logic            imem_req_ready_in,
  input  logic            imem_rsp_valid_in,
  input  logic [31:0]     imem_rsp_data_in,
  output logic            instr_valid_out,
  output logic [31:0]     instr_out,
  output logic [WORD-1:0] pc_out
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_OUT
  } state_t;

  state_t          r_state;
  logic [WORD-1:0] r_pc;
  logic            r_squash;
  logic            r_instr_valid;
  logic [31:0]     r_instr;
  logic [WORD-1:0] r_pc_out;

  logic [WORD-1:0] w_pc_inc;
  logic [WORD-1:0] w_target;

  // Wraps modulo 2^WORD by construction of the adder width.
  assign w_pc_inc = r_pc + PC_INC;
  // Targets are word aligned; the low two bits are cleared, not trapped.
  assign w_target = branch_target_in & ~WORD'(3);

  // The request must stay stable while memory withholds ready, so it is
  // decoded straight from state and PC rather than registered separately.
  assign imem_req_valid_out = (r_state == ST_FETCH);
  assign imem_addr_out      = r_pc;

  assign instr_valid_out = r_instr_valid;
  assign instr_out       = r_instr;
  assign pc_out          = r_pc_out;

  // NOTE: every register in this block, including the instruction holding
  // register, is cleared asynchronously so decode never sees stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_pc          <= RESET_PC;
      r_squash      <= 1'b0;
      r_instr_valid <= 1'b0;
      r_instr       <= '0;
      r_pc_out      <= RESET_PC;
    end else if (branch_taken_in) begin
      // NOTE: non-blocking assignments keep every branch of this FSM reading
      // the pre-edge state, so case order cannot change behaviour.
      r_pc          <= w_target;
      r_instr_valid <= 1'b0;
      unique case (r_state)
        ST_IDLE, ST_OUT: r_state <= ST_FETCH;
        ST_FETCH: begin
          // Old address was accepted: its response must be thrown away.
          if (imem_req_ready_in) begin
            r_squash <= 1'b1;
            r_state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rsp_valid_in) begin
            r_squash <= 1'b0;
            r_state  <= ST_FETCH;
          end else begin
            r_squash <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end else begin
      unique case (r_state)
        ST_IDLE: r_state <= ST_FETCH;
        ST_FETCH: begin
          if (imem_req_ready_in) r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_rsp_valid_in) begin
            if (r_squash) begin
              r_squash <= 1'b0;
              r_state  <= ST_FETCH;
            end else begin
              r_instr       <= imem_rsp_data_in;
              r_pc_out      <= r_pc;
              r_instr_valid <= 1'b1;
              r_pc          <= w_pc_inc;
              r_state       <= ST_OUT;
            end
          end
        end
        ST_OUT: begin
          if (!stall_in) begin
            r_instr_valid <= 1'b0;
            r_state       <= ST_FETCH;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
